// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU request scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rtl/alu_sched_rr_arbiter.sv - combinational round-robin arbiter
// Scans upward from the requester after last, wrapping, and grants the first one pending.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [id_w(N)-1:0]   last,
  output logic [N-1:0]         gnt,
  output logic [id_w(N)-1:0]   gnt_idx,
  output logic                 any
);

  localparam int IW = id_w(N);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shares one ALU between N_REQ requesters
// Round-robin accept, one-cycle issue, fixed-latency wait, then a held valid/ready response.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_ALU   = 4,
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 2,
  parameter int N_OPS   = 3
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*WIDTH*N_ALU-1:0]  req_a,
  input  logic [N_REQ*WIDTH*N_ALU-1:0]  req_b,
  input  logic [N_REQ*3-1:0]            req_sel,
  output logic [WIDTH*N_ALU-1:0]        alu_a,
  output logic [WIDTH*N_ALU-1:0]        alu_b,
  output logic [2:0]                    alu_select,
  output logic                          alu_enable,
  input  logic [WIDTH*N_ALU*8-1:0]      alu_out,
  input  logic                          alu_carry_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [id_w(N_REQ)-1:0]        rsp_id,
  output logic [2*WIDTH*N_ALU-1:0]      rsp_out,
  output logic                          rsp_carry,
  output logic                          rsp_err
);

  localparam int DW = WIDTH * N_ALU;
  localparam int IW = id_w(N_REQ);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t          state, state_nx;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx, last_grant;
  logic            any;
  logic [CW-1:0]   cnt;
  logic [2:0]      sel_g;
  logic            legal;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign sel_g = req_sel[int'(gnt_idx)*3 +: 3];
  assign legal = 32'(sel_g) < N_OPS;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_nx;
  end

  // Accept is gated by arst so no strobe leaks out while reset is held.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    alu_enable = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: if (any && arst) begin
        req_ready = gnt;
        state_nx  = legal ? ISSUE : RESP;
      end
      ISSUE: begin
        alu_enable = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      rsp_id     <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          last_grant <= gnt_idx;
          rsp_id     <= gnt_idx;
          // Illegal opcodes leave the ALU-facing registers untouched.
          if (legal) begin
            alu_a      <= req_a[int'(gnt_idx)*DW +: DW];
            alu_b      <= req_b[int'(gnt_idx)*DW +: DW];
            alu_select <= sel_g;
          end else begin
            rsp_err   <= 1'b1;
            rsp_out   <= '0;
            rsp_carry <= 1'b0;
          end
        end
        ISSUE: cnt <= CW'(ALU_LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            rsp_out   <= alu_out[2*DW-1:0];
            rsp_carry <= alu_carry_out;
            rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched
// Inputs change and outputs are sampled on the falling edge; the ALU is a combinational model.
module tb_alu_sched;

  localparam int DW = 16;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR*3-1:0]   req_sel;
  logic [DW-1:0]     alu_a, alu_b;
  logic [2:0]        alu_select;
  logic              alu_enable;
  logic [DW*8-1:0]   alu_out;
  logic              alu_carry_out;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*DW-1:0]   rsp_out;
  logic              rsp_carry, rsp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // ALU model: upper bits filled with a pattern so truncation is visible.
  logic [16:0] sum;
  logic [31:0] res;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    res = '0;
    alu_carry_out = 1'b0;
    case (alu_select)
      3'd0: begin res = {16'h0, sum[15:0]}; alu_carry_out = sum[16]; end
      3'd1: res = {16'h0, alu_a - alu_b};
      3'd2: res = 32'(alu_a) * 32'(alu_b);
      default: res = 32'hDEAD_BEEF;
    endcase
    alu_out = {{12{8'hA5}}, res};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    arst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset alu_enable", alu_enable, 0);
    chk("reset rsp_out", rsp_out, 0);
    arst = 1'b1;

    // Single add from requester 2
    @(negedge clk);
    req_a[2*DW +: DW] = 16'h00FF; req_b[2*DW +: DW] = 16'h0001; req_sel[2*3 +: 3] = 3'd0;
    req_valid = 4'b0100;
    #1 chk("add accept", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    chk("add enable c1", alu_enable, 1);
    chk("add alu_a c1", alu_a, 16'h00FF);
    @(negedge clk);
    chk("add enable c2", alu_enable, 0);
    chk("add rsp_valid c2", rsp_valid, 0);
    @(negedge clk);
    chk("add rsp_valid c3", rsp_valid, 0);
    @(negedge clk);
    chk("add rsp_valid c4", rsp_valid, 1);
    chk("add rsp_id", rsp_id, 2);
    chk("add rsp_out", rsp_out, 32'h0000_0100);
    chk("add rsp_err", rsp_err, 0);
    chk("add rsp_carry", rsp_carry, 0);
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    chk("add back to idle", rsp_valid, 0);

    // Illegal opcode from requester 1, then back-pressure
    req_a[1*DW +: DW] = 16'h1234; req_sel[1*3 +: 3] = 3'd5;
    req_valid = 4'b0010;
    #1 chk("ill accept", req_ready, 4'b0010);
    chk("ill no enable c0", alu_enable, 0);
    @(negedge clk);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[i*DW +: DW] = 16'(i + 1); req_b[i*DW +: DW] = 16'h0010; req_sel[i*3 +: 3] = 3'd0;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_err", rsp_err, 1);
      chk("bp rsp_out", rsp_out, 0);
      chk("bp rsp_id", rsp_id, 1);
      chk("bp req_ready", req_ready, 0);
      chk("bp no enable", alu_enable, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;

    // Round-robin with all valid: after requester 1, order is 2,3,0,1,2
    @(negedge clk);
    #1 chk("rr grant 0", req_ready, 4'b0100);
    for (int k = 1; k < 5; k++) begin
      for (int j = 1; j < 5; j++) begin
        @(negedge clk); #1;
        chk("rr gap req_ready", req_ready, 0);
        if (j == 4) begin
          chk("rr rsp_valid", rsp_valid, 1);
          chk("rr rsp_id", rsp_id, (k + 1) % 4);
          chk("rr rsp_out", rsp_out, 32'h11 + (k + 1) % 4);
        end
      end
      @(negedge clk); #1;
      chk("rr grant", req_ready, 4'b0001 << ((k + 2) % 4));
    end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rr last rsp_id", rsp_id, 2);
    chk("rr last rsp_valid", rsp_valid, 1);

    // Multiply from requester 3
    @(negedge clk);
    req_a[3*DW +: DW] = 16'hFFFF; req_b[3*DW +: DW] = 16'hFFFF; req_sel[3*3 +: 3] = 3'd2;
    req_valid = 4'b1000;
    #1 chk("mul accept", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0;
    chk("mul enable", alu_enable, 1);
    chk("mul select", alu_select, 2);
    for (int j = 2; j < 4; j++) begin
      @(negedge clk);
      chk("mul alu_a held", alu_a, 16'hFFFF);
      chk("mul alu_b held", alu_b, 16'hFFFF);
      chk("mul enable low", alu_enable, 0);
    end
    @(negedge clk);
    chk("mul rsp_valid", rsp_valid, 1);
    chk("mul rsp_id", rsp_id, 3);
    chk("mul rsp_out", rsp_out, 32'hFFFE_0001);

    // Reset during ISSUE aborts; afterwards requester 0 wins first
    @(negedge clk);
    req_valid = 4'b0001;
    #1 chk("rst accept", req_ready, 4'b0001);
    @(negedge clk); req_valid = 4'b1111;
    chk("rst pre enable", alu_enable, 1);
    arst = 1'b0;
    #1;
    chk("rst enable drop", alu_enable, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst rsp_out", rsp_out, 0);
    chk("rst rsp_id", rsp_id, 0);
    @(negedge clk);
    arst = 1'b1;
    #1 chk("rst first grant", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
